// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM bus initiator.
// States, the fixed read latency of the macro, and the strobe/mask encodings.
package sram_bus_pkg;

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        ACC,
        RCAP,
        RESP
    } sram_ini_state_e;

    localparam int         SRAM_RD_LAT = 1;
    localparam logic [3:0] MASK_FULL   = 4'hF;
    localparam logic [3:0] WSTRB_READ  = 4'h0;

    // A request with any byte strobe set is a write; all-zero strobes mean read.
    function automatic logic is_write(input logic [3:0] wstrb);
        return wstrb != WSTRB_READ;
    endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// Post-reset clear sequencer: walks a word address from 0 to DEPTH-1, one
// word per enabled cycle, and raises done once the last address was issued.
// Used by sram_bus_initiator only when SRAM_INIT_CLR_EN is defined.
module sram_clr_seq #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  done_o
);

    logic [ADDR_WIDTH-1:0] cnt_reg;
    logic                  done_reg;

    // Advance the clear address while enabled; latch done after the top word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (en_i && !done_reg) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign addr_o = cnt_reg;
    assign done_o = done_reg;

endmodule

// File: rtl/sram_bus_initiator.sv
// Initiator for a single-port SRAM macro (1-cycle read latency).
// Converts native valid/ready memory requests (wstrb==0 => read) into one
// registered chip-select access each. Write ready arrives 2 cycles after the
// request is sampled, read ready 3 cycles after.
// Optional feature: define SRAM_INIT_CLR_EN to zero the whole macro after
// reset before accepting requests; otherwise init_done_o is tied high.
module sram_bus_initiator
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic [3:0]            mem_wstrb_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  sram_cs_o,
    output logic                  sram_wren_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    output logic [3:0]            sram_mask_o,
    input  logic [31:0]           sram_rdata_i,
    output logic                  init_done_o
);

    sram_ini_state_e       state_reg;
    logic [3:0]            wstrb_reg;
    logic                  cs_reg;
    logic                  wren_reg;
    logic [3:0]            mask_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  ready_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Byte-offset bits and address bits above the macro depth alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

`ifdef SRAM_INIT_CLR_EN
    localparam sram_ini_state_e RESET_STATE = CLR;

    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_done;
    logic                  init_done_reg;

    sram_clr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_reg == CLR),
        .addr_o  (clr_addr),
        .done_o  (clr_done)
    );

    assign init_done_o = init_done_reg;
`else
    localparam sram_ini_state_e RESET_STATE = IDLE;

    assign init_done_o = 1'b1;
`endif

    // Request sequencer: one state per cycle, every macro and bus output registered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= RESET_STATE;
            wstrb_reg <= WSTRB_READ;
            cs_reg    <= 1'b0;
            wren_reg  <= 1'b0;
            mask_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ready_reg <= 1'b0;
            rdata_reg <= '0;
`ifdef SRAM_INIT_CLR_EN
            init_done_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
`ifdef SRAM_INIT_CLR_EN
                CLR: begin
                    // Bus requests are ignored until every word has been zeroed.
                    if (!clr_done) begin
                        cs_reg    <= 1'b1;
                        wren_reg  <= 1'b1;
                        mask_reg  <= MASK_FULL;
                        addr_reg  <= clr_addr;
                        wdata_reg <= '0;
                    end else begin
                        cs_reg        <= 1'b0;
                        wren_reg      <= 1'b0;
                        mask_reg      <= '0;
                        init_done_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
`endif
                IDLE: begin
                    if (mem_valid_i) begin
                        wstrb_reg <= mem_wstrb_i;
                        cs_reg    <= 1'b1;
                        wren_reg  <= is_write(mem_wstrb_i);
                        mask_reg  <= mem_wstrb_i;
                        addr_reg  <= mem_addr_i[ADDR_WIDTH+1:2];
                        wdata_reg <= mem_wdata_i;
                        state_reg <= ACC;
                    end
                end
                ACC: begin
                    // Address and write data keep their value so the macro pins stay quiet.
                    cs_reg   <= 1'b0;
                    wren_reg <= 1'b0;
                    mask_reg <= '0;
                    if (is_write(wstrb_reg)) begin
                        ready_reg <= 1'b1;
                        rdata_reg <= '0;
                        state_reg <= RESP;
                    end else begin
                        state_reg <= RCAP;
                    end
                end
                RCAP: begin
                    // Macro output is valid in the cycle after the read access.
                    rdata_reg <= sram_rdata_i;
                    ready_reg <= 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    ready_reg <= 1'b0;
                    rdata_reg <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    cs_reg    <= 1'b0;
                    wren_reg  <= 1'b0;
                    mask_reg  <= '0;
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sram_cs_o    = cs_reg;
    assign sram_wren_o  = wren_reg;
    assign sram_mask_o  = mask_reg;
    assign sram_addr_o  = addr_reg;
    assign sram_wdata_o = wdata_reg;
    assign mem_ready_o  = ready_reg;
    assign mem_rdata_o  = rdata_reg;

endmodule

// File: tb/tb_sram_bus_initiator.sv
// Self-checking bench for sram_bus_initiator with a behavioural 1024x32
// single-port SRAM (1-cycle registered read, byte mask on writes).
module tb_sram_bus_initiator;

    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          mem_valid_i = 1'b0;
    logic          mem_ready_o;
    logic [31:0]   mem_addr_i = '0;
    logic [31:0]   mem_wdata_i = '0;
    logic [3:0]    mem_wstrb_i = '0;
    logic [31:0]   mem_rdata_o;
    logic          sram_cs_o;
    logic          sram_wren_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [3:0]    sram_mask_o;
    logic [31:0]   sram_rdata_i = '0;
    logic          init_done_o;

    sram_bus_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_wstrb_i  (mem_wstrb_i),
        .mem_rdata_o  (mem_rdata_o),
        .sram_cs_o    (sram_cs_o),
        .sram_wren_o  (sram_wren_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_mask_o  (sram_mask_o),
        .sram_rdata_i (sram_rdata_i),
        .init_done_o  (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural macro model (tc_sram_1024x32)
    logic [31:0] sram_mem [0:1023];
    always @(posedge clk_i) begin
        if (sram_cs_o) begin
            if (sram_wren_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_mask_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

`ifdef SRAM_INIT_CLR_EN
    localparam logic INIT_AT_RESET = 1'b0;
`else
    localparam logic INIT_AT_RESET = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cs_cnt   = 0;
    int ready_cnt = 0;
    logic [31:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: count macro accesses and score every ready pulse against the queue.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (sram_cs_o) cs_cnt++;
            if (mem_ready_o) begin
                ready_cnt++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: rdata 0x%08h with no request outstanding", mem_rdata_o);
                end else begin
                    chk("rdata", mem_rdata_o, sb_q.pop_front());
                end
            end
        end
    end

    task automatic wait_init();
        int cyc = 0;
        while (!init_done_o && cyc < 2000) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        if (!init_done_o) chk("init_timeout", 32'(init_done_o), 32'd1);
    endtask

    // One complete transaction; valid asserted in the cycle after the previous RESP.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rd);
        int cyc = 0;
        int cs0;
        @(posedge clk_i); #1;
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_wstrb_i = wstrb;
        sb_q.push_back((wstrb == 4'h0) ? exp_rd : 32'h0);
        cs0 = cs_cnt;
        do begin
            @(posedge clk_i); #1;
            cyc++;
            if (cyc == 1) begin
                chk("acc_cs", 32'(sram_cs_o), 32'd1);
                chk("acc_wren", 32'(sram_wren_o), 32'(wstrb != 4'h0));
                chk("acc_mask", 32'(sram_mask_o), 32'(wstrb));
                chk("acc_addr", 32'(sram_addr_o), 32'(addr[AW+1:2]));
                if (wstrb != 4'h0) chk("acc_wdata", sram_wdata_o, wdata);
            end
        end while (!mem_ready_o && cyc < 20);
        chk((wstrb == 4'h0) ? "rd_latency" : "wr_latency", 32'(cyc), (wstrb == 4'h0) ? 32'd3 : 32'd2);
        chk("cs_pulses", 32'(cs_cnt - cs0), 32'd1);
        mem_valid_i = 1'b0;
        mem_wdata_i = $urandom;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin : main
        int cyc;
        int r0;
        int c0;

        tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[1] = '{32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[2] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
        tbl[3] = '{32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0};
        tbl[4] = '{32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
        tbl[5] = '{32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0};
        tbl[6] = '{32'h0000_1004, 32'h0,         4'h0, 32'hCAFE_F00D};
        tbl[7] = '{32'h0000_0007, 32'h0,         4'h0, 32'hCAFE_F00D};

        // Reset state
        #2;
        chk("rst_cs", 32'(sram_cs_o), 32'd0);
        chk("rst_ready", 32'(mem_ready_o), 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        chk("rst_addr", 32'(sram_addr_o), 32'd0);
        chk("rst_init_done", 32'(init_done_o), 32'(INIT_AT_RESET));
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        wait_init();

        // Directed vectors: single write/read, partial strobes, address aliasing
        for (int i = 0; i < 8; i++)
            do_txn(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].exp);

        // Back-to-back: 8 writes then 8 reads
        c0 = cs_cnt;
        for (int i = 0; i < 8; i++)
            do_txn(32'h100 + 32'(i) * 4, 32'hA500_0000 | (32'(i) * 32'h0001_0203), 4'hF, 32'h0);
        for (int i = 0; i < 8; i++)
            do_txn(32'h100 + 32'(i) * 4, 32'h0, 4'h0, 32'hA500_0000 | (32'(i) * 32'h0001_0203));
        chk("b2b_cs_total", 32'(cs_cnt - c0), 32'd16);

        // Address holds when idle
        repeat (3) @(posedge clk_i);
        #1 chk("addr_hold", 32'(sram_addr_o), 32'h47);

        // Valid dropped after one cycle: transaction still completes
        @(posedge clk_i); #1;
        mem_valid_i = 1'b1; mem_addr_i = 32'h10; mem_wstrb_i = 4'h0;
        sb_q.push_back(32'hDEAD_BEEF);
        r0 = ready_cnt;
        @(posedge clk_i); #1;
        mem_valid_i = 1'b0;
        cyc = 0;
        while (ready_cnt == r0 && cyc < 10) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("drop_valid_ready", 32'(ready_cnt - r0), 32'd1);

        // Reset during ACC of a read: abandoned, no ready
        @(posedge clk_i); #1;
        mem_valid_i = 1'b1; mem_addr_i = 32'h20; mem_wstrb_i = 4'h0;
        @(posedge clk_i); #1;
        chk("rst_acc_cs_before", 32'(sram_cs_o), 32'd1);
        r0 = ready_cnt;
        rst_n_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        chk("rst_acc_cs", 32'(sram_cs_o), 32'd0);
        chk("rst_acc_ready", 32'(mem_ready_o), 32'd0);
        chk("rst_acc_addr", 32'(sram_addr_o), 32'd0);
        chk("rst_acc_wdata", sram_wdata_o, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        wait_init();
        repeat (4) @(posedge clk_i);
        #1 chk("rst_acc_no_ready", 32'(ready_cnt - r0), 32'd0);
        do_txn(32'h24, 32'h5A5A_A5A5, 4'hF, 32'h0);
        do_txn(32'h24, 32'h0, 4'h0, 32'h5A5A_A5A5);

`ifdef SRAM_INIT_CLR_EN
        // Clear after reset with a read request pending
        do_txn(32'h3FC, 32'h1234_5678, 4'hF, 32'h0);
        do_txn(32'h3FC, 32'h0, 4'h0, 32'h1234_5678);
        @(posedge clk_i); #1;
        mem_valid_i = 1'b1; mem_addr_i = 32'h3FC; mem_wstrb_i = 4'h0;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        r0 = ready_cnt;
        c0 = cs_cnt;
        cyc = 0;
        while (!init_done_o && cyc < 2000) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("clr_init_cycles", 32'(cyc), 32'd1025);
        chk("clr_no_ready", 32'(ready_cnt - r0), 32'd0);
        chk("clr_cs_count", 32'(cs_cnt - c0), 32'd1024);
        sb_q.push_back(32'h0);
        cyc = 0;
        while (ready_cnt == r0 && cyc < 10) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("clr_pending_ready", 32'(ready_cnt - r0), 32'd1);
        mem_valid_i = 1'b0;
`endif

        repeat (4) @(posedge clk_i);
        #1 chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
